apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_addr_decoder.sv | 19 +
 rtl/apb_master.sv | 109 ++++++++++
 tb/tb_apb_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master and its address decoder.
package apb_pkg;

  localparam int          NUM_SLAVES        = 4;
  localparam int          IDX_W             = $clog2(NUM_SLAVES);
  localparam int          SLV_WINDOW_BITS   = 12;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a CPU address page onto one of the 4 KiB slave windows above BASE_ADDR.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic [31:SLV_WINDOW_BITS]         addr_page,
  output logic                              hit,
  output logic [IDX_W-1:0]                  idx
);

  // Only the region tag and the window number matter; the byte offset is never looked at.
  always_comb begin
    hit = (addr_page[31:16] == BASE_ADDR[31:16]) &&
          (addr_page[SLV_WINDOW_BITS+3:SLV_WINDOW_BITS] < 4'(NUM_SLAVES));
    idx = addr_page[SLV_WINDOW_BITS+IDX_W-1:SLV_WINDOW_BITS];
  end

endmodule

// File: rtl/apb_master.sv
// APB master bridging a simple CPU strobe interface to four APB slaves,
// with decode-miss and PREADY-timeout error completion.
module apb_master
  import apb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             transfer,
  input  logic                             write,
  input  logic [31:0]                      addr,
  input  logic [31:0]                      wdata,
  output logic [31:0]                      rdata,
  output logic                             ready,
  output logic                             err,
  output logic [31:0]                      PADDR,
  output logic                             PWRITE,
  output logic [31:0]                      PWDATA,
  output logic                             PENABLE,
  output logic [NUM_SLAVES-1:0]            PSEL,
  input  logic [NUM_SLAVES-1:0][31:0]      PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  apb_state_t        state_q, state_d;
  logic [31:0]       addr_q, wdata_q;
  logic              write_q, hit_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WAIT_W-1:0] wait_q;
  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;

  apb_addr_decoder #(.BASE_ADDR(BASE_ADDR)) u_decoder (
    .addr_page (addr[31:SLV_WINDOW_BITS]),
    .hit       (dec_hit),
    .idx       (dec_idx)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && transfer) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= write;
        hit_q   <= dec_hit;
        idx_q   <= dec_idx;
        wait_q  <= '0;
      end else if (state_q == ACCESS) begin
        wait_q  <= wait_q + WAIT_W'(1);
      end
    end
  end

  assign PADDR  = addr_q;
  assign PWDATA = wdata_q;
  assign PWRITE = write_q;

  // Completion outputs are combinational so ready lands in the same cycle as PREADY.
  always_comb begin
    state_d = state_q;
    PSEL    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    case (state_q)
      IDLE: begin
        if (transfer) state_d = SETUP;
      end
      SETUP: begin
        if (hit_q) PSEL = NUM_SLAVES'(1) << idx_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (hit_q) PSEL = NUM_SLAVES'(1) << idx_q;
        PENABLE = 1'b1;
        if (!hit_q) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else if (PREADY[idx_q]) begin
          ready   = 1'b1;
          rdata   = write_q ? 32'h0 : PRDATA[idx_q];
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master: hits, miss, timeout, reset abort, cross-talk.
module tb_apb_master;
  import apb_pkg::*;

  logic                        PCLK = 1'b0;
  logic                        PRESET;
  logic                        transfer, write;
  logic [31:0]                 addr, wdata;
  logic [31:0]                 rdata;
  logic                        ready, err;
  logic [31:0]                 PADDR, PWDATA;
  logic                        PWRITE, PENABLE;
  logic [NUM_SLAVES-1:0]       PSEL;
  logic [NUM_SLAVES-1:0][31:0] PRDATA;
  logic [NUM_SLAVES-1:0]       PREADY;

  int tests = 0;
  int fails = 0;

  apb_master #(.TIMEOUT_CYCLES(16), .BASE_ADDR(32'h1000_0000)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic applyStimulus(input logic t, input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = t;
    write    = w;
    addr     = a;
    wdata    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    PRESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    PRDATA = '0;
    PREADY = '0;
    #3;
    checkOutput("rst_psel",    32'(PSEL),    32'h0);
    checkOutput("rst_penable", 32'(PENABLE), 32'h0);
    checkOutput("rst_ready",   32'(ready),   32'h0);
    checkOutput("rst_paddr",   PADDR,        32'h0);
    tick();
    PRESET = 1'b0;

    // Write hit, slave 1 answers one cycle late
    tick();
    applyStimulus(1'b1, 1'b1, 32'h1000_1004, 32'h0000_00A5);
    PRDATA[1] = 32'hDEAD_BEEF;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("wr_setup_psel",    32'(PSEL),    32'h2);
    checkOutput("wr_setup_penable", 32'(PENABLE), 32'h0);
    checkOutput("wr_setup_ready",   32'(ready),   32'h0);
    checkOutput("wr_pwdata",        PWDATA,       32'h0000_00A5);
    checkOutput("wr_paddr",         PADDR,        32'h1000_1004);
    tick();
    #1;
    checkOutput("wr_acc1_penable", 32'(PENABLE), 32'h1);
    checkOutput("wr_acc1_psel",    32'(PSEL),    32'h2);
    checkOutput("wr_acc1_ready",   32'(ready),   32'h0);
    tick();
    PREADY = 4'b0010;
    #1;
    checkOutput("wr_acc2_penable", 32'(PENABLE), 32'h1);
    checkOutput("wr_acc2_ready",   32'(ready),   32'h1);
    checkOutput("wr_acc2_err",     32'(err),     32'h0);
    checkOutput("wr_acc2_rdata",   rdata,        32'h0);
    checkOutput("wr_pwrite",       32'(PWRITE),  32'h1);
    tick();
    PREADY = '0;
    #1;
    checkOutput("wr_idle_psel",    32'(PSEL),    32'h0);
    checkOutput("wr_idle_penable", 32'(PENABLE), 32'h0);
    checkOutput("wr_idle_ready",   32'(ready),   32'h0);

    // Read hit, slave 2 ready immediately
    applyStimulus(1'b1, 1'b0, 32'h1000_2008, 32'h0);
    PRDATA[2] = 32'h0000_005A;
    PREADY = 4'b0100;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("rd_setup_psel",  32'(PSEL),  32'h4);
    checkOutput("rd_setup_ready", 32'(ready), 32'h0);
    tick();
    #1;
    checkOutput("rd_acc_ready", 32'(ready), 32'h1);
    checkOutput("rd_acc_err",   32'(err),   32'h0);
    checkOutput("rd_acc_rdata", rdata,      32'h0000_005A);
    tick();
    PREADY = '0;
    #1;
    checkOutput("rd_idle_ready", 32'(ready), 32'h0);

    // Decode miss
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    PRDATA = {4{32'h1234_5678}};
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("miss_setup_psel",  32'(PSEL),  32'h0);
    checkOutput("miss_setup_ready", 32'(ready), 32'h0);
    tick();
    #1;
    checkOutput("miss_acc_psel",    32'(PSEL),    32'h0);
    checkOutput("miss_acc_penable", 32'(PENABLE), 32'h1);
    checkOutput("miss_acc_ready",   32'(ready),   32'h1);
    checkOutput("miss_acc_err",     32'(err),     32'h1);
    checkOutput("miss_acc_rdata",   rdata,        32'h0);
    tick();
    #1;
    checkOutput("miss_idle_ready", 32'(ready), 32'h0);

    // Timeout on slave 3 while the other slaves all claim ready
    applyStimulus(1'b1, 1'b0, 32'h1000_3000, 32'h0);
    PREADY = 4'b0111;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("tmo_setup_psel", 32'(PSEL), 32'h8);
    for (int i = 1; i <= 15; i++) begin
      tick();
      #1;
      checkOutput($sformatf("tmo_wait%0d_ready", i), 32'(ready), 32'h0);
    end
    tick();
    #1;
    checkOutput("tmo_acc16_ready", 32'(ready), 32'h1);
    checkOutput("tmo_acc16_err",   32'(err),   32'h1);
    checkOutput("tmo_acc16_rdata", rdata,      32'h0);
    tick();
    PREADY = '0;
    #1;
    checkOutput("tmo_idle_penable", 32'(PENABLE), 32'h0);
    checkOutput("tmo_idle_ready",   32'(ready),   32'h0);

    // Cross-talk: slave 0 ready must not complete a slave 2 access
    applyStimulus(1'b1, 1'b0, 32'h1000_2000, 32'h0);
    PRDATA[2] = 32'hCAFE_0002;
    PREADY = 4'b0001;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      #1;
      checkOutput($sformatf("xt_acc%0d_ready", i), 32'(ready), 32'h0);
    end
    tick();
    PREADY = 4'b0101;
    #1;
    checkOutput("xt_done_ready", 32'(ready), 32'h1);
    checkOutput("xt_done_err",   32'(err),   32'h0);
    checkOutput("xt_done_rdata", rdata,      32'hCAFE_0002);
    tick();
    PREADY = '0;

    // Reset in the middle of an ACCESS cycle, then a fresh write right after release
    applyStimulus(1'b1, 1'b1, 32'h1000_0010, 32'h0000_0077);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    #1;
    checkOutput("rst_pre_penable", 32'(PENABLE), 32'h1);
    PRESET = 1'b1;
    #1;
    checkOutput("rst_mid_psel",    32'(PSEL),    32'h0);
    checkOutput("rst_mid_penable", 32'(PENABLE), 32'h0);
    checkOutput("rst_mid_ready",   32'(ready),   32'h0);
    checkOutput("rst_mid_paddr",   PADDR,        32'h0);
    applyStimulus(1'b1, 1'b1, 32'h1000_0020, 32'h0000_0099);
    tick();
    checkOutput("rst_hold_ready", 32'(ready), 32'h0);
    PRESET = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("post_setup_psel", 32'(PSEL),  32'h1);
    checkOutput("post_pwdata",     PWDATA,     32'h0000_0099);
    tick();
    PREADY = 4'b0001;
    #1;
    checkOutput("post_acc_ready", 32'(ready), 32'h1);
    checkOutput("post_acc_err",   32'(err),   32'h0);
    tick();
    PREADY = '0;
    #1;
    checkOutput("post_idle_ready", 32'(ready), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
